decode_execute_stage: RTL and testbench

//  Decode->execute boundary of the 5-stage pipeline: captures register-file read data, immediate and

---
 rtl/decode_execute_stage_pkg.sv | 38 +++
 rtl/decode_execute_stage_if.sv | 31 +++
 rtl/decode_execute_stage_hazard_unit.sv | 72 +++++++
 rtl/decode_execute_stage.sv | 132 +++++++++++++
 tb/tb_decode_execute_stage.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_execute_stage_pkg.sv
// Shared types for the decode/execute boundary of the 5-stage pipeline.
// The decoder, this stage and the execute logic all use these types.
//   ctrl_t     : control bits produced by the decoder and carried into E
//   alu_op_t   : ALU operation encoding carried in ctrl_t.alucontrol
//   fwd_sel_t  : operand source chosen by the hazard unit
//   PC_IDX_DEFAULT : register index that reads PC+8 (r15)
package decode_execute_stage_pkg;

  localparam int PC_IDX_DEFAULT = 15;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    alu_op_t    alucontrol;
    logic [1:0] flagwrite;
    logic       branch;
    logic [3:0] cond;
  } ctrl_t;

  // An all-zero control word: no register, memory, flag or PC write.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_execute_stage_if.sv
// D-stage bundle presented to the decode/execute boundary.
//   valid_d          : D-stage holds a real instruction
//   ra1_d, ra2_d     : source register indices (also driven to the register file)
//   wa3_d            : destination register index
//   rd1_d, rd2_d     : register-file read data for ra1_d / ra2_d
//   extimm_d         : extended immediate
//   ctrl_d           : decoded control bits
// master = decoder / register-file side, slave = decode_execute_stage.
interface decode_execute_stage_if
  import decode_execute_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              valid_d;
  logic [REG_AW-1:0] ra1_d;
  logic [REG_AW-1:0] ra2_d;
  logic [REG_AW-1:0] wa3_d;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;
  logic [DATA_W-1:0] extimm_d;
  ctrl_t             ctrl_d;

  modport master (
    output valid_d, ra1_d, ra2_d, wa3_d, rd1_d, rd2_d, extimm_d, ctrl_d
  );

  modport slave (
    input valid_d, ra1_d, ra2_d, wa3_d, rd1_d, rd2_d, extimm_d, ctrl_d
  );
endinterface

// File: rtl/decode_execute_stage_hazard_unit.sv
// Combinational hazard logic for the decode/execute boundary.
// Inputs : D-stage sources, E-stage register indices and load/write flags,
//          M/W write-back indices and enables, resolved branch in E.
// Outputs: fwd_a/fwd_b operand source selects, ldstall, stall_f, stall_d,
//          flush_d, flush_e.
module decode_execute_stage_hazard_unit
  import decode_execute_stage_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_IDX = PC_IDX_DEFAULT
) (
  input  logic              valid_d,
  input  logic [REG_AW-1:0] ra1_d,
  input  logic [REG_AW-1:0] ra2_d,
  input  logic              valid_e,
  input  logic [REG_AW-1:0] ra1_e,
  input  logic [REG_AW-1:0] ra2_e,
  input  logic [REG_AW-1:0] wa3_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] wa3_m,
  input  logic              regwrite_w,
  input  logic [REG_AW-1:0] wa3_w,
  input  logic              branch_taken_e,
  output fwd_sel_t          fwd_a,
  output fwd_sel_t          fwd_b,
  output logic              ldstall,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e
);

  localparam logic [REG_AW-1:0] PC_REG = REG_AW'(PC_IDX);

  // The PC register is never written through the pipeline's forwarding
  // paths, so it is excluded; M is younger than W and therefore wins.
  function automatic fwd_sel_t pick_src(
    input logic [REG_AW-1:0] ra,
    input logic              rw_m,
    input logic [REG_AW-1:0] wa_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] wa_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (rw_m && (wa_m == ra)) begin
        sel = FWD_M;
      end else if (rw_w && (wa_w == ra)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  // A load in E cannot forward its data to the instruction in D in time,
  // so D is held one cycle and a bubble enters E. A taken branch redirects
  // fetch, which makes any stall pointless, so it overrides the stall.
  always_comb begin
    fwd_a   = pick_src(ra1_e, regwrite_m, wa3_m, regwrite_w, wa3_w);
    fwd_b   = pick_src(ra2_e, regwrite_m, wa3_m, regwrite_w, wa3_w);
    ldstall = valid_e && memtoreg_e && regwrite_e && valid_d &&
              (wa3_e != PC_REG) && ((wa3_e == ra1_d) || (wa3_e == ra2_d));
    stall_f = ldstall && !branch_taken_e;
    stall_d = ldstall && !branch_taken_e;
    flush_d = branch_taken_e;
    flush_e = ldstall || branch_taken_e;
  end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode->execute boundary of the 5-stage pipeline.
// Captures D-stage operands/immediate/control into the E register, applies
// M/W->E forwarding, resolves load-use and branch hazards, and counts
// load-use stall cycles.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   d_bus             : D-stage bundle (decode_execute_stage_if.slave)
//   aluresult_m, regwrite_m, wa3_m : M-stage write-back source
//   result_w, regwrite_w, wa3_w    : W-stage write-back source
//   branch_taken_e    : branch/PC write in E resolved taken
//   srca_e, writedata_e, srcb_e    : forwarded ALU operands / store data
//   wa3_e, ctrl_e, valid_e         : registered E-stage destination/control
//   stall_f, stall_d, flush_d      : pipeline control for F and D
//   stall_count       : saturating count of load-use stall cycles
module decode_execute_stage
  import decode_execute_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int PC_IDX = PC_IDX_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  decode_execute_stage_if.slave d_bus,
  input  logic [DATA_W-1:0] aluresult_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] wa3_m,
  input  logic [DATA_W-1:0] result_w,
  input  logic              regwrite_w,
  input  logic [REG_AW-1:0] wa3_w,
  input  logic              branch_taken_e,
  output logic [DATA_W-1:0] srca_e,
  output logic [DATA_W-1:0] writedata_e,
  output logic [DATA_W-1:0] srcb_e,
  output logic [REG_AW-1:0] wa3_e,
  output ctrl_t             ctrl_e,
  output logic              valid_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] rd1_e;
  logic [DATA_W-1:0] rd2_e;
  logic [DATA_W-1:0] extimm_e;
  logic [REG_AW-1:0] ra1_e;
  logic [REG_AW-1:0] ra2_e;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic              ldstall;
  logic              flush_e;

  decode_execute_stage_hazard_unit #(
    .REG_AW (REG_AW),
    .PC_IDX (PC_IDX)
  ) hazard_unit (
    .valid_d        (d_bus.valid_d),
    .ra1_d          (d_bus.ra1_d),
    .ra2_d          (d_bus.ra2_d),
    .valid_e        (valid_e),
    .ra1_e          (ra1_e),
    .ra2_e          (ra2_e),
    .wa3_e          (wa3_e),
    .regwrite_e     (ctrl_e.regwrite),
    .memtoreg_e     (ctrl_e.memtoreg),
    .regwrite_m     (regwrite_m),
    .wa3_m          (wa3_m),
    .regwrite_w     (regwrite_w),
    .wa3_w          (wa3_w),
    .branch_taken_e (branch_taken_e),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .ldstall        (ldstall),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e)
  );

  // E register: a flush loads an all-zero bubble so no write enable of the
  // squashed instruction can survive into later stages.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      rd1_e    <= '0;
      rd2_e    <= '0;
      extimm_e <= '0;
      ra1_e    <= '0;
      ra2_e    <= '0;
      wa3_e    <= '0;
      ctrl_e   <= CTRL_BUBBLE;
      valid_e  <= 1'b0;
    end else begin
      rd1_e    <= d_bus.rd1_d;
      rd2_e    <= d_bus.rd2_d;
      extimm_e <= d_bus.extimm_d;
      ra1_e    <= d_bus.ra1_d;
      ra2_e    <= d_bus.ra2_d;
      wa3_e    <= d_bus.wa3_d;
      ctrl_e   <= d_bus.ctrl_d;
      valid_e  <= d_bus.valid_d;
    end
  end

  // Only stall cycles that actually hold the pipeline are counted; a
  // redirecting branch in the same cycle cancels the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (ldstall && !branch_taken_e && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  always_comb begin
    case (fwd_a)
      FWD_M:   srca_e = aluresult_m;
      FWD_W:   srca_e = result_w;
      default: srca_e = rd1_e;
    endcase
    case (fwd_b)
      FWD_M:   writedata_e = aluresult_m;
      FWD_W:   writedata_e = result_w;
      default: writedata_e = rd2_e;
    endcase
    srcb_e = ctrl_e.alusrc ? extimm_e : writedata_e;
  end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Testbench for decode_execute_stage: directed scenarios for reset,
// forwarding priority, PC exclusion, load-use stall, branch override and
// counter saturation, followed by randomized traffic checked against a
// behavioural model of the E stage.
module tb_decode_execute_stage;
  import decode_execute_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] aluresult_m;
  logic              regwrite_m;
  logic [REG_AW-1:0] wa3_m;
  logic [DATA_W-1:0] result_w;
  logic              regwrite_w;
  logic [REG_AW-1:0] wa3_w;
  logic              branch_taken_e;
  logic [DATA_W-1:0] srca_e;
  logic [DATA_W-1:0] writedata_e;
  logic [DATA_W-1:0] srcb_e;
  logic [REG_AW-1:0] wa3_e;
  ctrl_t             ctrl_e;
  logic              valid_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic [CNT_W-1:0]  stall_count;

  int n_compared;
  int n_mismatched;

  decode_execute_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) d_if ();

  decode_execute_stage #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .PC_IDX (15),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .d_bus          (d_if),
    .aluresult_m    (aluresult_m),
    .regwrite_m     (regwrite_m),
    .wa3_m          (wa3_m),
    .result_w       (result_w),
    .regwrite_w     (regwrite_w),
    .wa3_w          (wa3_w),
    .branch_taken_e (branch_taken_e),
    .srca_e         (srca_e),
    .writedata_e    (writedata_e),
    .srcb_e         (srcb_e),
    .wa3_e          (wa3_e),
    .ctrl_e         (ctrl_e),
    .valid_e        (valid_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the instruction currently sitting in E, as a snapshot
  // of what D presented when it was accepted, plus the stall tally.
  typedef struct packed {
    logic        valid;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    ctrl_t       ctrl;
  } slot_t;

  slot_t m_e;
  int    m_count;

  // The value an instruction should see for register ra: the youngest
  // in-flight writer of ra, or the register file if none (r15 never bypassed).
  function automatic logic [31:0] model_operand(input logic [3:0] ra, input logic [31:0] rf_val);
    if (ra == 4'd15) return rf_val;
    if (regwrite_m && wa3_m == ra) return aluresult_m;
    if (regwrite_w && wa3_w == ra) return result_w;
    return rf_val;
  endfunction

  // D needs a value that a load in E has not fetched yet.
  function automatic logic model_load_use();
    logic d_reads;
    d_reads = (d_if.ra1_d == m_e.wa3) || (d_if.ra2_d == m_e.wa3);
    return m_e.valid && m_e.ctrl.memtoreg && m_e.ctrl.regwrite && d_if.valid_d &&
           (m_e.wa3 != 4'd15) && d_reads;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_e     <= '0;
      m_count <= 0;
    end else begin
      if (branch_taken_e || model_load_use()) begin
        m_e <= '0;
      end else begin
        m_e <= '{d_if.valid_d, d_if.ra1_d, d_if.ra2_d, d_if.wa3_d,
                 d_if.rd1_d, d_if.rd2_d, d_if.extimm_d, d_if.ctrl_d};
      end
      if (model_load_use() && !branch_taken_e && m_count < CNT_MAX) begin
        m_count <= m_count + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_if.valid_d   = 1'b0;
    d_if.ra1_d     = '0;
    d_if.ra2_d     = '0;
    d_if.wa3_d     = '0;
    d_if.rd1_d     = '0;
    d_if.rd2_d     = '0;
    d_if.extimm_d  = '0;
    d_if.ctrl_d    = CTRL_BUBBLE;
    aluresult_m    = '0;
    regwrite_m     = 1'b0;
    wa3_m          = '0;
    result_w       = '0;
    regwrite_w     = 1'b0;
    wa3_w          = '0;
    branch_taken_e = 1'b0;
  endtask

  function automatic ctrl_t mk_ctrl(input logic rw, input logic mtr, input logic asrc);
    ctrl_t c;
    c          = CTRL_BUBBLE;
    c.regwrite = rw;
    c.memtoreg = mtr;
    c.alusrc   = asrc;
    return c;
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_compared++;
    if (valid_e !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected 0", valid_e);
    end
    n_compared++;
    if (stall_count !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_count: got %0d expected 0", stall_count);
    end
    d_if.valid_d = 1'b1;
    d_if.wa3_d   = 4'd9;
    d_if.ra1_d   = 4'd1;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b0, 1'b0);
    tick();
    n_compared++;
    if (valid_e !== 1'b1 || wa3_e !== 4'd9) begin
      n_mismatched++;
      $display("[TB] FAIL capture: got valid=%b wa3=%0d expected valid=1 wa3=9", valid_e, wa3_e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_compared++;
    if (valid_e !== 1'b0 || ctrl_e !== CTRL_BUBBLE || wa3_e !== 4'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_midstream: got valid=%b ctrl=%h wa3=%0d expected 0/0/0",
               valid_e, ctrl_e, wa3_e);
    end
    n_compared++;
    if (stall_count !== '0 || stall_f !== 1'b0 || flush_d !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got count=%0d stall_f=%b flush_d=%b expected 0/0/0",
               stall_count, stall_f, flush_d);
    end
  endtask

  task automatic test_m_forward();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.ra1_d   = 4'd3;
    d_if.rd1_d   = 32'h33;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    regwrite_m  = 1'b1;
    wa3_m       = 4'd3;
    aluresult_m = 32'h11;
    regwrite_w  = 1'b1;
    wa3_w       = 4'd3;
    result_w    = 32'h22;
    #1;
    n_compared++;
    if (srca_e !== 32'h11) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_m_priority: got %h expected 00000011", srca_e);
    end
    regwrite_m = 1'b0;
    #1;
    n_compared++;
    if (srca_e !== 32'h22) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_w_a: got %h expected 00000022", srca_e);
    end
    regwrite_w = 1'b0;
    #1;
    n_compared++;
    if (srca_e !== 32'h33) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_none_a: got %h expected 00000033", srca_e);
    end
  endtask

  task automatic test_w_forward();
    clear_inputs();
    d_if.valid_d  = 1'b1;
    d_if.ra2_d    = 4'd5;
    d_if.rd2_d    = 32'h1234;
    d_if.extimm_d = 32'h4;
    d_if.ctrl_d   = mk_ctrl(1'b1, 1'b0, 1'b1);
    tick();
    clear_inputs();
    regwrite_m  = 1'b1;
    wa3_m       = 4'd6;
    aluresult_m = 32'hBEEF;
    regwrite_w  = 1'b1;
    wa3_w       = 4'd5;
    result_w    = 32'hDEAD;
    #1;
    n_compared++;
    if (writedata_e !== 32'hDEAD) begin
      n_mismatched++;
      $display("[TB] FAIL fwd_w_b: got %h expected 0000dead", writedata_e);
    end
    n_compared++;
    if (srcb_e !== 32'h4) begin
      n_mismatched++;
      $display("[TB] FAIL srcb_imm: got %h expected 00000004", srcb_e);
    end
  endtask

  task automatic test_pc_exclusion();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.ra1_d   = 4'd15;
    d_if.rd1_d   = 32'h108;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    regwrite_m  = 1'b1;
    wa3_m       = 4'd15;
    aluresult_m = 32'hBAD;
    regwrite_w  = 1'b1;
    wa3_w       = 4'd15;
    result_w    = 32'hBAD2;
    #1;
    n_compared++;
    if (srca_e !== 32'h108) begin
      n_mismatched++;
      $display("[TB] FAIL pc_no_fwd: got %h expected 00000108", srca_e);
    end
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.wa3_d   = 4'd15;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b1, 1'b0);
    tick();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.ra1_d   = 4'd15;
    d_if.ra2_d   = 4'd15;
    d_if.wa3_d   = 4'd3;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b0, 1'b0);
    #1;
    n_compared++;
    if (stall_f !== 1'b0 || stall_d !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL pc_no_stall: got stall_f=%b stall_d=%b expected 0/0", stall_f, stall_d);
    end
    tick();
    n_compared++;
    if (valid_e !== 1'b1 || wa3_e !== 4'd3) begin
      n_mismatched++;
      $display("[TB] FAIL pc_no_bubble: got valid=%b wa3=%0d expected 1/3", valid_e, wa3_e);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.wa3_d   = 4'd2;
    d_if.ra1_d   = 4'd7;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b1, 1'b0);
    tick();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.ra1_d   = 4'd1;
    d_if.ra2_d   = 4'd2;
    d_if.wa3_d   = 4'd4;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b0, 1'b0);
    #1;
    n_compared++;
    if (stall_f !== 1'b1 || stall_d !== 1'b1 || flush_d !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ldstall_assert: got stall_f=%b stall_d=%b flush_d=%b expected 1/1/0",
               stall_f, stall_d, flush_d);
    end
    tick();
    n_compared++;
    if (valid_e !== 1'b0 || ctrl_e !== CTRL_BUBBLE) begin
      n_mismatched++;
      $display("[TB] FAIL ldstall_bubble: got valid=%b ctrl=%h expected 0/0", valid_e, ctrl_e);
    end
    n_compared++;
    if (stall_count !== 8'd1 || stall_f !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ldstall_count: got count=%0d stall_f=%b expected 1/0", stall_count, stall_f);
    end
    tick();
    n_compared++;
    if (valid_e !== 1'b1 || wa3_e !== 4'd4 || stall_count !== 8'd1) begin
      n_mismatched++;
      $display("[TB] FAIL ldstall_proceed: got valid=%b wa3=%0d count=%0d expected 1/4/1",
               valid_e, wa3_e, stall_count);
    end
  endtask

  task automatic test_branch_ldstall();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.wa3_d   = 4'd2;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b1, 1'b0);
    tick();
    clear_inputs();
    d_if.valid_d   = 1'b1;
    d_if.ra1_d     = 4'd2;
    d_if.wa3_d     = 4'd5;
    d_if.ctrl_d    = mk_ctrl(1'b1, 1'b0, 1'b0);
    branch_taken_e = 1'b1;
    #1;
    n_compared++;
    if (flush_d !== 1'b1 || stall_f !== 1'b0 || stall_d !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL branch_beats_stall: got flush_d=%b stall_f=%b stall_d=%b expected 1/0/0",
               flush_d, stall_f, stall_d);
    end
    tick();
    branch_taken_e = 1'b0;
    #1;
    n_compared++;
    if (stall_count !== 8'd1 || valid_e !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL branch_count_hold: got count=%0d valid=%b expected 1/0", stall_count, valid_e);
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    d_if.valid_d = 1'b1;
    d_if.wa3_d   = 4'd2;
    d_if.ra1_d   = 4'd2;
    d_if.ctrl_d  = mk_ctrl(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      tick();
    end
    n_compared++;
    if (stall_count !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL count_saturate: got %h expected ff", stall_count);
    end
    tick();
    tick();
    n_compared++;
    if (stall_count !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL count_hold_max: got %h expected ff", stall_count);
    end
  endtask

  function automatic logic [3:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] exp_a;
    logic [31:0] exp_wd;
    logic [31:0] exp_b;
    logic        exp_stall;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      d_if.valid_d   = ($urandom_range(0, 3) != 0);
      d_if.ra1_d     = rand_reg();
      d_if.ra2_d     = rand_reg();
      d_if.wa3_d     = rand_reg();
      d_if.rd1_d     = $urandom;
      d_if.rd2_d     = $urandom;
      d_if.extimm_d  = $urandom;
      r              = $urandom;
      d_if.ctrl_d    = ctrl_t'(r[12:0]);
      regwrite_m     = r[20];
      wa3_m          = rand_reg();
      aluresult_m    = $urandom;
      regwrite_w     = r[21];
      wa3_w          = rand_reg();
      result_w       = $urandom;
      branch_taken_e = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      exp_a     = model_operand(m_e.ra1, m_e.rd1);
      exp_wd    = model_operand(m_e.ra2, m_e.rd2);
      exp_b     = m_e.ctrl.alusrc ? m_e.imm : exp_wd;
      exp_stall = model_load_use() && !branch_taken_e;
      n_compared++;
      if (srca_e !== exp_a || writedata_e !== exp_wd || srcb_e !== exp_b) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_operands[%0d]: got a=%h wd=%h b=%h expected a=%h wd=%h b=%h",
                 i, srca_e, writedata_e, srcb_e, exp_a, exp_wd, exp_b);
      end
      n_compared++;
      if (valid_e !== m_e.valid || wa3_e !== m_e.wa3 || ctrl_e !== m_e.ctrl) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_ereg[%0d]: got v=%b wa3=%0d ctrl=%h expected v=%b wa3=%0d ctrl=%h",
                 i, valid_e, wa3_e, ctrl_e, m_e.valid, m_e.wa3, m_e.ctrl);
      end
      n_compared++;
      if (stall_f !== exp_stall || stall_d !== exp_stall || flush_d !== branch_taken_e) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_hazard[%0d]: got sf=%b sd=%b fd=%b expected sf=%b sd=%b fd=%b",
                 i, stall_f, stall_d, flush_d, exp_stall, exp_stall, branch_taken_e);
      end
      n_compared++;
      if (stall_count !== CNT_W'(m_count)) begin
        n_mismatched++;
        $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, stall_count, m_count);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    clear_inputs();
    $display("[TB] decode_execute_stage bench start");
    test_reset();
    test_m_forward();
    test_w_forward();
    test_pc_exclusion();
    test_load_use();
    test_branch_ldstall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
